parity_push_source: RTL and testbench



---
 rtl/parity_push_source.sv | 125 ++++++++++++
 tb/tb_parity_push_source.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_push_source.sv
// rtl/parity_push_source.sv - parity-encoding push source with 2-entry skid buffer
// Optional feature: PARITY_PUSH_ERR_INJECT_EN adds err_inject_i to corrupt a word's parity.
module parity_push_source #(
    parameter int DATA_WIDTH = 32,
    parameter int EVEN_ODD   = 0,
    parameter int PARITY_BIT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    output logic [DATA_WIDTH:0]   push_data_o,
    output logic                  push_valid_o,
    input  logic                  push_grant_i,
`ifdef PARITY_PUSH_ERR_INJECT_EN
    input  logic                  err_inject_i,
`endif
    output logic [15:0]           sent_count_o
);

    localparam logic POLARITY = (EVEN_ODD != 0);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_WIDTH:0] head_q, head_d;
    logic [DATA_WIDTH:0] skid_q, skid_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic [15:0]         count_q, count_d;

    logic                flip;
    logic                parity;
    logic [DATA_WIDTH:0] enc_word;
    logic                acc;
    logic                drn;

`ifdef PARITY_PUSH_ERR_INJECT_EN
    assign flip = err_inject_i;
`else
    assign flip = 1'b0;
`endif

    assign parity = (^src_data_i) ^ POLARITY ^ flip;

    generate
        if (PARITY_BIT == 0) begin : g_par_lsb
            assign enc_word = {src_data_i, parity};
        end else begin : g_par_msb
            assign enc_word = {parity, src_data_i};
        end
    endgenerate

    // Grant only counts when a word is actually presented; it is ignored in EMPTY.
    assign acc = src_valid_i && ready_q;
    assign drn = valid_q && push_grant_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        if (drn) begin
            count_d = count_q + 16'd1;
        end
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    head_d  = enc_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && drn) begin
                    head_d = enc_word;
                end else if (acc) begin
                    skid_d  = enc_word;
                    state_d = ST_FULL;
                end else if (drn) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drn) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        ready_d = (state_d != ST_FULL);
        valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign src_ready_o  = ready_q;
    assign push_valid_o = valid_q;
    assign push_data_o  = head_q;
    assign sent_count_o = count_q;

endmodule

// File: tb/tb_parity_push_source.sv
// tb/tb_parity_push_source.sv - directed self-checking bench for parity_push_source
// Error-injection steps run only when PARITY_PUSH_ERR_INJECT_EN is defined.
module tb_parity_push_source;

    logic        clk;
    logic        rst;
    logic [31:0] src_data;
    logic        src_valid;
    logic        push_grant;
    logic        err_inject;

    logic        rdy0, rdy1, rdy2;
    logic        pv0, pv1, pv2;
    logic [32:0] pd0, pd1, pd2;
    logic [15:0] cnt0, cnt1, cnt2;

    int checks;
    int errors;
    int n;
    int budget;

    logic [63:0] stream_exp [1:10];

    parity_push_source #(.DATA_WIDTH(32), .EVEN_ODD(0), .PARITY_BIT(0)) dut0 (
        .clk(clk), .rst(rst), .src_data_i(src_data), .src_valid_i(src_valid),
        .src_ready_o(rdy0), .push_data_o(pd0), .push_valid_o(pv0),
        .push_grant_i(push_grant),
`ifdef PARITY_PUSH_ERR_INJECT_EN
        .err_inject_i(err_inject),
`endif
        .sent_count_o(cnt0)
    );

    parity_push_source #(.DATA_WIDTH(32), .EVEN_ODD(1), .PARITY_BIT(0)) dut_odd (
        .clk(clk), .rst(rst), .src_data_i(src_data), .src_valid_i(src_valid),
        .src_ready_o(rdy1), .push_data_o(pd1), .push_valid_o(pv1),
        .push_grant_i(push_grant),
`ifdef PARITY_PUSH_ERR_INJECT_EN
        .err_inject_i(err_inject),
`endif
        .sent_count_o(cnt1)
    );

    parity_push_source #(.DATA_WIDTH(32), .EVEN_ODD(0), .PARITY_BIT(1)) dut_msb (
        .clk(clk), .rst(rst), .src_data_i(src_data), .src_valid_i(src_valid),
        .src_ready_o(rdy2), .push_data_o(pd2), .push_valid_o(pv2),
        .push_grant_i(push_grant),
`ifdef PARITY_PUSH_ERR_INJECT_EN
        .err_inject_i(err_inject),
`endif
        .sent_count_o(cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stream_exp[1] = 64'd3;   stream_exp[2] = 64'd5;
        stream_exp[3] = 64'd6;   stream_exp[4] = 64'd9;
        stream_exp[5] = 64'd10;  stream_exp[6] = 64'd12;
        stream_exp[7] = 64'd15;  stream_exp[8] = 64'd17;
        stream_exp[9] = 64'd18;  stream_exp[10] = 64'd20;

        clk        = 1'b0;
        rst        = 1'b1;
        src_valid  = 1'b1;
        src_data   = 32'hDEAD_BEEF;
        push_grant = 1'b0;
        err_inject = 1'b0;

        // Reset held 3 cycles with a valid source
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_push_valid", {63'd0, pv0}, 64'd0);
        chk("rst_src_ready", {63'd0, rdy0}, 64'd0);
        chk("rst_sent_count", {48'd0, cnt0}, 64'd0);
        chk("rst_push_data", {31'd0, pd0}, 64'd0);
        rst       = 1'b0;
        src_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, rdy0}, 64'd1);
        chk("post_rst_push_valid", {63'd0, pv0}, 64'd0);

        // Encoding across three parameterisations
        src_data   = 32'h0000_0001;
        src_valid  = 1'b1;
        push_grant = 1'b1;
        @(negedge clk);
        chk("enc_even_lsb_1", {31'd0, pd0}, 64'h0_0000_0003);
        chk("enc_odd_lsb_1", {31'd0, pd1}, 64'h0_0000_0002);
        chk("enc_even_msb_1", {31'd0, pd2}, 64'h1_0000_0001);
        chk("enc_latency_valid", {63'd0, pv0}, 64'd1);
        src_data = 32'h0000_0003;
        @(negedge clk);
        chk("enc_even_lsb_3", {31'd0, pd0}, 64'h0_0000_0006);
        chk("enc_sent_1", {48'd0, cnt0}, 64'd1);
        src_valid = 1'b0;
        @(negedge clk);
        chk("enc_sent_2", {48'd0, cnt0}, 64'd2);
        chk("enc_drained", {63'd0, pv0}, 64'd0);

        // Reset clears the counter
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_sent", {48'd0, cnt0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Streaming 1..10 with grant held high
        for (int i = 1; i <= 11; i++) begin
            if (i > 1) begin
                chk($sformatf("stream_data_%0d", i - 1), {31'd0, pd0}, stream_exp[i - 1]);
                chk($sformatf("stream_valid_%0d", i - 1), {63'd0, pv0}, 64'd1);
            end
            chk($sformatf("stream_ready_%0d", i), {63'd0, rdy0}, 64'd1);
            if (i <= 10) begin
                src_data  = i;
                src_valid = 1'b1;
            end else begin
                src_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream_sent", {48'd0, cnt0}, 64'd10);
        chk("stream_empty", {63'd0, pv0}, 64'd0);

        // Backpressure: A=0x11, B=0x7, C=0x80000000
        push_grant = 1'b0;
        src_data   = 32'h0000_0011;
        src_valid  = 1'b1;
        @(negedge clk);
        chk("bp_a_data", {31'd0, pd0}, 64'h0_0000_0022);
        chk("bp_ready_after_a", {63'd0, rdy0}, 64'd1);
        src_data = 32'h0000_0007;
        @(negedge clk);
        chk("bp_ready_after_b", {63'd0, rdy0}, 64'd0);
        chk("bp_a_stable1", {31'd0, pd0}, 64'h0_0000_0022);
        src_data = 32'h8000_0000;
        @(negedge clk);
        chk("bp_ready_held", {63'd0, rdy0}, 64'd0);
        chk("bp_a_stable2", {31'd0, pd0}, 64'h0_0000_0022);
        chk("bp_valid_held", {63'd0, pv0}, 64'd1);
        chk("bp_sent_frozen", {48'd0, cnt0}, 64'd10);
        push_grant = 1'b1;
        @(negedge clk);
        chk("bp_b_data", {31'd0, pd0}, 64'h0_0000_000F);
        chk("bp_ready_back", {63'd0, rdy0}, 64'd1);
        @(negedge clk);
        chk("bp_c_data", {31'd0, pd0}, 64'h1_0000_0001);
        src_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty", {63'd0, pv0}, 64'd0);
        chk("bp_sent", {48'd0, cnt0}, 64'd13);

        // Reset with two words buffered discards them
        push_grant = 1'b0;
        src_data   = 32'h0000_0005;
        src_valid  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_full_ready", {63'd0, rdy0}, 64'd0);
        rst       = 1'b1;
        src_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {63'd0, pv0}, 64'd0);
        chk("mid_rst_ready", {63'd0, rdy0}, 64'd0);
        chk("mid_rst_data", {31'd0, pd0}, 64'd0);
        chk("mid_rst_sent", {48'd0, cnt0}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_ready", {63'd0, rdy0}, 64'd1);

        // Counter wrap after 65537 push transfers
        push_grant = 1'b1;
        src_valid  = 1'b1;
        src_data   = 32'h0000_00A5;
        n      = 0;
        budget = 0;
        while (n < 65537 && budget < 70000) begin
            @(negedge clk);
            if (pv0) n++;
            budget++;
        end
        @(posedge clk);
        #1;
        push_grant = 1'b0;
        src_valid  = 1'b0;
        @(negedge clk);
        chk("wrap_budget", n, 64'd65537);
        chk("wrap_sent", {48'd0, cnt0}, 64'd1);

`ifdef PARITY_PUSH_ERR_INJECT_EN
        push_grant = 1'b1;
        @(negedge clk);
        @(negedge clk);
        src_data   = 32'h0000_0001;
        src_valid  = 1'b1;
        err_inject = 1'b1;
        @(negedge clk);
        chk("inj_corrupt", {31'd0, pd0}, 64'h0_0000_0002);
        err_inject = 1'b0;
        @(negedge clk);
        chk("inj_clean", {31'd0, pd0}, 64'h0_0000_0003);
        src_valid = 1'b0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
